// File: rtl/player_pkg.sv
// Shared types and constants for the playback controller: FSM states, function-key
// bit positions, track number width and the wrap-around track stepping helper.
package player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PLAY  = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  localparam int FN_CONT   = 0;
  localparam int FN_PAUSE  = 1;
  localparam int FN_VOL_UP = 2;
  localparam int FN_VOL_DN = 3;
  localparam int FN_NEXT   = 4;
  localparam int FN_PREV   = 5;

  localparam int TRACK_W = 4;

  // Step the track number up or down by one, wrapping within 1..num.
  function automatic logic [TRACK_W-1:0] track_wrap(input logic [TRACK_W-1:0] cur,
                                                    input logic up,
                                                    input int unsigned num);
    if (up) return (cur >= TRACK_W'(num)) ? TRACK_W'(1) : cur + TRACK_W'(1);
    else    return (cur <= TRACK_W'(1)) ? TRACK_W'(num) : cur - TRACK_W'(1);
  endfunction

endpackage

// File: rtl/player_ctrl_key_repeat.sv
// Rising-edge detector for one held key level, with an optional hold-to-repeat
// counter that emits an extra event every REPEAT_CYC cycles while the key stays high.
module key_repeat #(
  parameter bit REPEAT_EN  = 1'b0,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic evt_o
);

  logic key_q;
  logic rep;

  always_ff @(posedge clk) begin
    if (rst) key_q <= 1'b0;
    else     key_q <= key_i;
  end

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int CW = $clog2(REPEAT_CYC + 1);
      logic [CW-1:0] cnt_q;

      // cnt_q counts edges since the key went high; reaching REPEAT_CYC fires and restarts at 1.
      always_ff @(posedge clk) begin
        if (rst || !key_i)                 cnt_q <= '0;
        else if (cnt_q == CW'(REPEAT_CYC)) cnt_q <= CW'(1);
        else                               cnt_q <= cnt_q + CW'(1);
      end

      assign rep = key_i && (cnt_q == CW'(REPEAT_CYC));
    end else begin : g_norep
      assign rep = 1'b0;
    end
  endgenerate

  assign evt_o = (key_i & ~key_q) | rep;

endmodule

// File: rtl/player_ctrl.sv
// Playback controller: turns held key levels into events, resolves them by priority
// and sequences IDLE/LOAD/PLAY/PAUSE, driving track, volume and the restart strobe.
module player_ctrl
  import player_pkg::*;
#(
  parameter int NUM_TRACKS  = 9,
  parameter int VOL_W       = 3,
  parameter int VOL_DEFAULT = 4,
  parameter int REPEAT_CYC  = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_TRACKS-1:0] trk_key,
  input  logic [5:0]            fn_key,
  input  logic                  track_done,
  output logic [TRACK_W-1:0]    track,
  output logic [VOL_W-1:0]      volume,
  output logic                  playing,
  output logic                  paused,
  output logic                  restart,
  output logic [1:0]            state_dbg
);

  localparam logic [VOL_W-1:0] VOL_MAX = '1;

  logic [NUM_TRACKS-1:0] trk_evt;
  logic [5:0]            fn_evt;

  for (genvar i = 0; i < NUM_TRACKS; i++) begin : g_trk
    key_repeat #(.REPEAT_EN(1'b0), .REPEAT_CYC(REPEAT_CYC)) u_key (
      .clk(clk), .rst(rst), .key_i(trk_key[i]), .evt_o(trk_evt[i])
    );
  end

  for (genvar i = 0; i < 6; i++) begin : g_fn
    key_repeat #(.REPEAT_EN(i == FN_VOL_UP || i == FN_VOL_DN), .REPEAT_CYC(REPEAT_CYC)) u_key (
      .clk(clk), .rst(rst), .key_i(fn_key[i]), .evt_o(fn_evt[i])
    );
  end

  state_e             state_q, state_d;
  logic [TRACK_W-1:0] track_q, track_d;
  logic [VOL_W-1:0]   vol_q;
  logic               playing_q, paused_q, restart_q;
  logic               sel_hit;
  logic [TRACK_W-1:0] sel_num;

  always_comb begin
    sel_hit = 1'b0;
    sel_num = '0;
    // Scan downward so the lowest-numbered select is the one left standing.
    for (int i = NUM_TRACKS - 1; i >= 0; i--) begin
      if (trk_evt[i]) begin
        sel_hit = 1'b1;
        sel_num = TRACK_W'(i + 1);
      end
    end

    state_d = state_q;
    track_d = track_q;
    if (sel_hit) begin
      track_d = sel_num;
      state_d = ST_LOAD;
    end else if (fn_evt[FN_NEXT]) begin
      track_d = track_wrap(track_q, 1'b1, NUM_TRACKS);
      state_d = ST_LOAD;
    end else if (fn_evt[FN_PREV]) begin
      track_d = track_wrap(track_q, 1'b0, NUM_TRACKS);
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  state_d = ST_PLAY;
        ST_PLAY: begin
          if (fn_evt[FN_PAUSE]) begin
            state_d = ST_PAUSE;
          end else if (track_done) begin
            if (track_q < TRACK_W'(NUM_TRACKS)) begin
              track_d = track_q + TRACK_W'(1);
              state_d = ST_LOAD;
            end else begin
              track_d = TRACK_W'(1);
              state_d = ST_IDLE;
            end
          end
        end
        ST_PAUSE: if (fn_evt[FN_CONT]) state_d = ST_PLAY;
        ST_IDLE:  if (fn_evt[FN_CONT]) state_d = ST_LOAD;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      track_q   <= TRACK_W'(1);
      vol_q     <= VOL_W'(VOL_DEFAULT);
      playing_q <= 1'b0;
      paused_q  <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      track_q   <= track_d;
      playing_q <= (state_d == ST_PLAY);
      paused_q  <= (state_d == ST_PAUSE);
      restart_q <= (state_d == ST_LOAD);
      if (fn_evt[FN_VOL_UP] && !fn_evt[FN_VOL_DN] && vol_q != VOL_MAX)
        vol_q <= vol_q + VOL_W'(1);
      else if (fn_evt[FN_VOL_DN] && !fn_evt[FN_VOL_UP] && vol_q != '0)
        vol_q <= vol_q - VOL_W'(1);
    end
  end

  assign track     = track_q;
  assign volume    = vol_q;
  assign playing   = playing_q;
  assign paused    = paused_q;
  assign restart   = restart_q;
  assign state_dbg = state_q;

endmodule
